// File: rtl/data_lane_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : data_lane_sequencer
//  Description : Distributes an upstream word stream over 8 alignment lanes
//                (West 1-4, North 1-4), BURST words per lane per frame, and
//                waits for every lane FIFO to drain before the next frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_lane_sequencer #(
    parameter int W     = 32,
    parameter int BURST = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         enable,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic [7:0]   lane_full,
    input  logic [7:0]   lane_empty,
    output logic [W-1:0] data,
    output logic         select,
    output logic [2:0]   rptr,
    output logic         frame_done,
    output logic [7:0]   frame_cnt,
    output logic         busy
);

    localparam logic [1:0] c_S_IDLE       = 2'd0;
    localparam logic [1:0] c_S_LOAD       = 2'd1;
    localparam logic [1:0] c_S_WAIT_DRAIN = 2'd2;

    // Word index of the last word of a lane burst
    localparam logic [7:0] c_CNT_LAST = 8'(BURST - 1);
    localparam logic [2:0] c_LP_LAST  = 3'd7;

    logic [1:0]   r_state;
    logic [1:0]   w_next_state;
    logic [2:0]   r_lp;
    logic [7:0]   r_cnt;
    logic [W-1:0] r_data;
    logic [2:0]   r_rptr;
    logic         r_select;
    logic         r_frame_done;
    logic [7:0]   r_frame_cnt;

    logic         w_in_ready;
    logic         w_busy;
    logic         w_hs;
    logic         w_burst_end;
    logic         w_frame_end;
    logic         w_enter_load;

    assign w_hs         = in_valid && w_in_ready;
    assign w_burst_end  = (r_cnt == c_CNT_LAST);
    assign w_frame_end  = w_hs && w_burst_end && (r_lp == c_LP_LAST);
    // Both IDLE->LOAD and WAIT_DRAIN->LOAD restart the lane walk from lane 0
    assign w_enter_load = (r_state != c_S_LOAD) && (w_next_state == c_S_LOAD);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; enable only matters in IDLE and when leaving drain
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (enable) begin
                    w_next_state = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                if (w_frame_end) begin
                    w_next_state = c_S_WAIT_DRAIN;
                end
            end
            c_S_WAIT_DRAIN: begin
                if (lane_empty == 8'hFF) begin
                    w_next_state = enable ? c_S_LOAD : c_S_IDLE;
                end
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // State-decoded outputs: accept only in LOAD while the current lane has room
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        case (r_state)
            c_S_LOAD: begin
                w_in_ready = !lane_full[r_lp];
                w_busy     = 1'b1;
            end
            c_S_WAIT_DRAIN: begin
                w_busy = 1'b1;
            end
            default: begin
                w_in_ready = 1'b0;
                w_busy     = 1'b0;
            end
        endcase
    end

    // Lane pointer / burst word counter; lp wraps 7->0 naturally at frame end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lp  <= 3'd0;
            r_cnt <= 8'd0;
        end else if (w_enter_load) begin
            r_lp  <= 3'd0;
            r_cnt <= 8'd0;
        end else if (w_hs) begin
            if (w_burst_end) begin
                r_cnt <= 8'd0;
                r_lp  <= r_lp + 3'd1;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Switch-side outputs: one cycle after each handshake; data/rptr hold otherwise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data   <= '0;
            r_rptr   <= 3'd0;
            r_select <= 1'b0;
        end else begin
            r_select <= w_hs;
            if (w_hs) begin
                r_data <= in_data;
                r_rptr <= r_lp;
            end
        end
    end

    // Frame completion pulse, aligned with the final select, and frame counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 8'd0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_frame_end) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign busy       = w_busy;
    assign data       = r_data;
    assign rptr       = r_rptr;
    assign select     = r_select;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: doc/data_lane_sequencer.md
DATA_LANE_SEQUENCER -- requirements
Module: data_lane_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, meaning payload width in bits.
REQ-002 SHALL have parameter BURST, default 4, meaning words per lane per frame; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, meaning permission to start a frame.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-007 SHALL have port in_data, input, W, meaning the upstream payload.
REQ-008 SHALL have port in_ready, output, 1, meaning the sequencer accepts in_data this cycle.
REQ-009 SHALL have port lane_full, input, 8, meaning per-lane alignment FIFO full; bits 0-3 are West 1-4 and bits 4-7 are North 1-4.
REQ-010 SHALL have port lane_empty, input, 8, meaning per-lane alignment FIFO empty, with the same bit order as lane_full.
REQ-011 SHALL have port data, output, W, meaning the payload to the switch.
REQ-012 SHALL have port select, output, 1, meaning data and rptr are valid to the switch this cycle.
REQ-013 SHALL have port rptr, output, 3, meaning the destination lane index.
REQ-014 SHALL have port frame_done, output, 1, meaning a one-cycle pulse when all 8 lanes have been loaded.
REQ-015 SHALL have port frame_cnt, output, 8, meaning completed-frame count; wraps 255 -> 0.
REQ-016 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD and WAIT_DRAIN, with internal lane pointer lp (3 bits) and word counter cnt (8 bits).
REQ-018 SHALL move IDLE -> LOAD when enable=1 and set lp=0 and cnt=0 on entry.
REQ-019 SHALL drive in_ready = (state==LOAD) && !lane_full[lp] combinationally; in_ready SHALL be 0 in all other states.
REQ-020 SHALL treat in_valid && in_ready at a rising edge as a handshake; in_data SHALL be consumed only on a handshake.
REQ-021 SHALL, on each handshake, register data<=in_data, rptr<=lp and select<=1, so that all three appear exactly 1 cycle after the handshake.
REQ-022 SHALL set select<=0 in any cycle without a handshake; data and rptr SHALL then hold their last values.
REQ-023 SHALL, on a handshake with cnt<BURST-1, increment cnt and leave lp unchanged.
REQ-024 SHALL, on a handshake with cnt==BURST-1 and lp<7, set cnt<=0 and lp<=lp+1.
REQ-025 SHALL, on a handshake with cnt==BURST-1 and lp==7, set cnt<=0 and lp<=0, pulse frame_done for 1 cycle coincident with the final select, increment frame_cnt, and enter WAIT_DRAIN.
REQ-026 SHALL stall while lane_full[lp]=1 in LOAD, including mid-burst: no handshake, and cnt and lp held; loading SHALL resume with the next word when full drops.
REQ-027 SHALL stall while in_valid=0 in LOAD, with no state change.
REQ-028 SHALL leave WAIT_DRAIN when lane_empty==8'hFF: go to LOAD if enable=1, otherwise to IDLE.
REQ-029 SHALL sample enable only in IDLE and on WAIT_DRAIN exit; deasserting enable in LOAD SHALL NOT abort the current frame.
REQ-030 SHALL drive busy=1 in LOAD and WAIT_DRAIN.
REQ-031 SHALL, for BURST=1, advance lp on every handshake.

Reset
REQ-032 SHALL, while resetn=0, immediately force state=IDLE, lp=0, cnt=0, data=0, select=0, rptr=0, frame_done=0, frame_cnt=0 and busy=0, with in_ready=0.
REQ-033 SHALL, on reset mid-frame, discard the partial frame and not emit frame_done; after release it SHALL stay in IDLE until enable=1.

Verification
REQ-034 SHALL cover a full frame: BURST=4, enable=1, in_valid=1 continuously, lane_full=0 -> 32 select pulses with rptr sequence 0,0,0,0,1,...,7,7,7,7, data matching inputs in order, frame_done on the 32nd select, frame_cnt=1.
REQ-035 SHALL cover backpressure: lane_full[2]=1 asserted after the 2nd word to lane 2, held 5 cycles -> in_ready=0 for those cycles, no select, then the 3rd lane-2 word is delivered with rptr=2.
REQ-036 SHALL cover drain gating: after frame_done with lane_empty=8'h7F held 10 cycles -> in_ready stays 0 and busy=1; lane_empty=8'hFF with enable=1 -> LOAD next cycle, next select carries rptr=0.
REQ-037 SHALL cover reset mid-frame: resetn pulsed low after 13 handshakes -> all outputs 0 immediately, no frame_done, frame_cnt=0; a restart delivers the first word with rptr=0.
REQ-038 SHALL cover enable drop and wrap: enable=0 during LOAD -> the frame completes and the FSM returns to IDLE after drain; run 256 frames -> frame_cnt wraps to 0.
